// File: rtl/wind_mean_window_if.sv
`default_nettype none
// ============================================================================
//  Module   : wind_mean_window_if
//  Purpose  : Sample/mean bus of the wind speed running-mean stage.
//             master drives the sample stream and configuration;
//             slave (the averager) returns the mean, ready pulse and fill.
//  Signals  : enable  - block enable
//             sample  - 1-cycle strobe, din valid
//             din     - signed input sample (DATA_W)
//             meanlen - log2 window length request (clamped by the slave)
//             mode    - 0 = block mean, 1 = sliding mean
//             clear   - synchronous window restart
//             mean    - signed mean, held between ready pulses (DATA_W)
//             ready   - 1-cycle pulse, mean updated
//             fill    - samples in the current window (MAXLEN+1)
//  Revision : 1.0 - initial release
// ============================================================================
interface wind_mean_window_if #(
   parameter int DATA_W = 16,
   parameter int MAXLEN = 6
);
   logic                     enable;
   logic                     sample;
   logic signed [DATA_W-1:0] din;
   logic        [3:0]        meanlen;
   logic                     mode;
   logic                     clear;
   logic signed [DATA_W-1:0] mean;
   logic                     ready;
   logic        [MAXLEN:0]   fill;

   modport master (
      output enable, sample, din, meanlen, mode, clear,
      input  mean, ready, fill
   );

   modport slave (
      input  enable, sample, din, meanlen, mode, clear,
      output mean, ready, fill
   );
endinterface
`default_nettype wire

// File: rtl/wind_mean_window.sv
`default_nettype none
// ============================================================================
//  Module   : wind_mean_window
//  Purpose  : Running mean of a signed wind speed sample stream over 2^L
//             samples, L = min(meanlen, MAXLEN). Block mode emits one mean per
//             window; sliding mode emits one mean per sample once the window
//             is full. Rounding is toward minus infinity (arithmetic shift).
//  Ports    : clock - system clock, rising edge
//             reset - asynchronous, active-low reset
//             bus   - wind_mean_window_if.slave (sample stream in, mean out)
//  Revision : 1.0 - initial release
// ============================================================================
module wind_mean_window #(
   parameter int DATA_W = 16,
   parameter int MAXLEN = 6,
   parameter int ACC_W  = DATA_W + MAXLEN
) (
   input  wire logic          clock,
   input  wire logic          reset,
   wind_mean_window_if.slave  bus
);

   localparam int              DEPTH    = 1 << MAXLEN;
   localparam logic [3:0]      MAXLEN_L = 4'(MAXLEN);
   localparam logic [MAXLEN:0] FILL_ONE = (MAXLEN+1)'(1);
   localparam logic [MAXLEN-1:0] PTR_ONE = MAXLEN'(1);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_STEADY  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t                   state_q,  state_d;
   logic signed [ACC_W-1:0]  acc_q,    acc_d;
   logic        [MAXLEN:0]   fill_q,   fill_d;
   logic        [MAXLEN-1:0] wr_ptr_q, wr_ptr_d;
   logic        [3:0]        l_q,      l_d;
   logic                     mode_q,   mode_d;
   logic signed [DATA_W-1:0] mean_q,   mean_d;
   logic                     ready_q,  ready_d;

   // History of the most recent samples; only read once the window is full,
   // so its contents never need clearing.
   logic signed [DATA_W-1:0] hist_q [DEPTH];

   // ---------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------
   logic        [3:0]        len_clamped;
   logic                     restart;
   logic                     accept;
   logic        [MAXLEN:0]   win_n;
   logic        [MAXLEN:0]   last_cnt;
   logic        [MAXLEN-1:0] rd_idx;
   logic signed [ACC_W-1:0]  din_ext;
   logic signed [ACC_W-1:0]  old_ext;
   logic signed [ACC_W-1:0]  sum;
   logic                     hist_we;

   always_comb begin
      len_clamped = (bus.meanlen > MAXLEN_L) ? MAXLEN_L : bus.meanlen;
      // Any change of window length or mode invalidates the running sum.
      restart     = bus.enable & (bus.clear | (len_clamped != l_q) | (bus.mode != mode_q));
      accept      = bus.enable & bus.sample & ~restart;
      win_n       = FILL_ONE << l_q;
      last_cnt    = win_n - FILL_ONE;
      // Sample leaving the sliding window; for a full-depth window this is
      // the slot about to be overwritten, read before the write lands.
      rd_idx      = wr_ptr_q - win_n[MAXLEN-1:0];
      din_ext     = ACC_W'(bus.din);
      old_ext     = ACC_W'(hist_q[rd_idx]);
   end

   // ---------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      fill_d   = fill_q;
      wr_ptr_d = wr_ptr_q;
      l_d      = l_q;
      mode_d   = mode_q;
      mean_d   = mean_q;
      ready_d  = 1'b0;
      hist_we  = 1'b0;
      sum      = acc_q + din_ext;

      if (restart) begin
         acc_d   = '0;
         fill_d  = '0;
         state_d = ST_EMPTY;
         l_d     = len_clamped;
         mode_d  = bus.mode;
      end else if (accept) begin
         hist_we  = 1'b1;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         case (state_q)
            ST_EMPTY, ST_FILLING: begin
               if (fill_q == last_cnt) begin
                  // This sample completes the window.
                  mean_d  = DATA_W'(sum >>> l_q);
                  ready_d = 1'b1;
                  if (mode_q) begin
                     acc_d   = sum;
                     fill_d  = win_n;
                     state_d = ST_STEADY;
                  end else begin
                     acc_d   = '0;
                     fill_d  = '0;
                     state_d = ST_EMPTY;
                  end
               end else begin
                  acc_d   = sum;
                  fill_d  = fill_q + FILL_ONE;
                  state_d = ST_FILLING;
               end
            end
            ST_STEADY: begin
               // Slide: add the newest sample, drop the oldest.
               sum     = acc_q + din_ext - old_ext;
               acc_d   = sum;
               mean_d  = DATA_W'(sum >>> l_q);
               ready_d = 1'b1;
            end
            default: begin
               acc_d   = '0;
               fill_d  = '0;
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_EMPTY;
         acc_q    <= '0;
         fill_q   <= '0;
         wr_ptr_q <= '0;
         l_q      <= '0;
         mode_q   <= 1'b0;
         mean_q   <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         fill_q   <= fill_d;
         wr_ptr_q <= wr_ptr_d;
         l_q      <= l_d;
         mode_q   <= mode_d;
         mean_q   <= mean_d;
         ready_q  <= ready_d;
      end
   end

   always_ff @(posedge clock) begin
      if (hist_we) begin
         hist_q[wr_ptr_q] <= bus.din;
      end
   end

   assign bus.mean  = mean_q;
   assign bus.ready = ready_q;
   assign bus.fill  = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_wind_mean_window.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wind_mean_window
//  Purpose  : Self-checking bench for wind_mean_window: directed scenarios
//             with literal expectations plus randomized traffic compared every
//             cycle against a queue-based window model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wind_mean_window;
   localparam int DATA_W = 16;
   localparam int MAXLEN = 6;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   wind_mean_window_if #(.DATA_W(DATA_W), .MAXLEN(MAXLEN)) bus ();

   wind_mean_window #(.DATA_W(DATA_W), .MAXLEN(MAXLEN)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: the window is a plain queue of accepted samples.
   // ---------------------------------------------------------------------
   int win_q[$];
   int m_L;
   bit m_mode;
   int m_mean;
   bit m_ready;
   int m_fill;

   function automatic int floor_div(longint s, int n);
      longint q;
      q = s / n;
      if ((s % n) != 0 && s < 0) q = q - 1;
      return int'(q);
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         win_q.delete();
         m_L = 0; m_mode = 0; m_mean = 0; m_ready = 0; m_fill = 0;
      end else begin
         int     cl;
         longint s;
         m_ready = 0;
         if (bus.enable) begin
            cl = (int'(bus.meanlen) > MAXLEN) ? MAXLEN : int'(bus.meanlen);
            if (bus.clear || cl != m_L || bus.mode != m_mode) begin
               win_q.delete();
               m_L    = cl;
               m_mode = bus.mode;
            end else if (bus.sample) begin
               win_q.push_back(int'(bus.din));
               if (m_mode && win_q.size() > (1 << m_L)) void'(win_q.pop_front());
               if (win_q.size() == (1 << m_L)) begin
                  s = 0;
                  foreach (win_q[i]) s += win_q[i];
                  m_mean  = floor_div(s, 1 << m_L);
                  m_ready = 1;
                  if (!m_mode) win_q.delete();
               end
            end
         end
         m_fill = win_q.size();
      end
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         chk("model_mean",  signed'(bus.mean), m_mean);
         chk("model_ready", bus.ready,         m_ready);
         chk("model_fill",  bus.fill,          m_fill);
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int v);
      bus.sample = 1'b1;
      bus.din    = DATA_W'(v);
      tick();
      bus.sample = 1'b0;
   endtask

   // Restart the window with a given mode/length (clear forces a restart
   // even when the configuration is unchanged).
   task automatic cfg(input bit m, input int len);
      bus.enable  = 1'b1;
      bus.mode    = m;
      bus.meanlen = 4'(len);
      bus.clear   = 1'b1;
      tick();
      bus.clear   = 1'b0;
   endtask

   initial begin
      int cnt;
      reset       = 1'b0;
      bus.enable  = 1'b0;
      bus.sample  = 1'b0;
      bus.din     = '0;
      bus.meanlen = '0;
      bus.mode    = 1'b0;
      bus.clear   = 1'b0;
      tick();
      tick();
      chk("reset_mean",  signed'(bus.mean), 0);
      chk("reset_ready", bus.ready, 0);
      chk("reset_fill",  bus.fill, 0);
      reset  = 1'b1;
      cmp_en = 1'b1;

      // T1: block, N=4
      cfg(0, 2);
      push(4);  chk("t1_fill1", bus.fill, 1); chk("t1_rdy1", bus.ready, 0);
      push(8);  chk("t1_fill2", bus.fill, 2);
      push(12); chk("t1_fill3", bus.fill, 3); chk("t1_rdy3", bus.ready, 0);
      push(16); chk("t1_rdy4", bus.ready, 1); chk("t1_mean", signed'(bus.mean), 10);
      chk("t1_fill4", bus.fill, 0);
      tick();   chk("t1_rdy_drop", bus.ready, 0); chk("t1_mean_hold", signed'(bus.mean), 10);

      // T2: block, N=2, negative rounding
      cfg(0, 1);
      push(-3); push(-4);
      chk("t2_rdy", bus.ready, 1); chk("t2_mean_neg", signed'(bus.mean), -4);
      push(7); push(7);
      chk("t2_mean_pos", signed'(bus.mean), 7);

      // T3: sliding, N=4
      cfg(1, 2);
      for (int i = 1; i <= 6; i++) begin
         push(i);
         if (i < 4) chk("t3_no_rdy", bus.ready, 0);
         else begin
            chk("t3_rdy", bus.ready, 1);
            chk("t3_mean", signed'(bus.mean), i - 2);
         end
      end
      chk("t3_fill_sat", bus.fill, 4);

      // T4: meanlen clamps to MAXLEN
      cfg(0, 9);
      cnt = 0;
      for (int i = 0; i < 63; i++) begin
         push(100);
         if (bus.ready) cnt++;
      end
      chk("t4_early_rdy", cnt, 0);
      chk("t4_fill63", bus.fill, 63);
      push(100);
      chk("t4_rdy", bus.ready, 1); chk("t4_mean", signed'(bus.mean), 100);

      // T5: reset mid-window
      cfg(0, 2);
      push(9); push(3);
      chk("t5_fill_pre", bus.fill, 2);
      reset = 1'b0;
      #1;
      chk("t5_rst_mean", signed'(bus.mean), 0);
      chk("t5_rst_ready", bus.ready, 0);
      chk("t5_rst_fill", bus.fill, 0);
      tick();
      reset = 1'b1;
      cfg(0, 2);
      for (int i = 0; i < 4; i++) push(5);
      chk("t5_rdy", bus.ready, 1); chk("t5_mean", signed'(bus.mean), 5);

      // T6: clear drops the sample; length change restarts; enable=0 holds
      cfg(0, 2);
      push(7); chk("t6_fill1", bus.fill, 1);
      bus.clear = 1'b1; bus.sample = 1'b1; bus.din = 16'sd50;
      tick();
      bus.clear = 1'b0; bus.sample = 1'b0;
      chk("t6_clear_fill", bus.fill, 0); chk("t6_clear_rdy", bus.ready, 0);
      cfg(1, 1);
      push(10); push(20);
      chk("t6_sl_mean1", signed'(bus.mean), 15);
      push(30);
      chk("t6_sl_mean2", signed'(bus.mean), 25); chk("t6_sl_fill", bus.fill, 2);
      bus.meanlen = 4'd2;
      tick();
      chk("t6_len_fill", bus.fill, 0);
      cnt = 0;
      push(1); cnt += int'(bus.ready);
      push(2); cnt += int'(bus.ready);
      push(3); cnt += int'(bus.ready);
      chk("t6_len_no_rdy", cnt, 0);
      push(6);
      chk("t6_len_rdy", bus.ready, 1); chk("t6_len_mean", signed'(bus.mean), 3);
      bus.enable = 1'b0;
      push(100); push(100); push(100);
      chk("t6_dis_rdy", bus.ready, 0); chk("t6_dis_fill", bus.fill, 4);
      chk("t6_dis_mean", signed'(bus.mean), 3);
      bus.enable = 1'b1;

      // L=0 in both modes
      cfg(1, 0);
      push(-5); chk("l0_sl_rdy", bus.ready, 1); chk("l0_sl_mean", signed'(bus.mean), -5);
      push(11); chk("l0_sl_mean2", signed'(bus.mean), 11);
      cfg(0, 0);
      push(9);  chk("l0_bl_mean", signed'(bus.mean), 9); chk("l0_bl_fill", bus.fill, 0);

      // Randomized traffic, checked every cycle by the model comparator
      for (int c = 0; c < 4000; c++) begin
         bus.enable = ($urandom % 10) != 0;
         bus.sample = ($urandom % 4) != 0;
         bus.din    = DATA_W'($urandom);
         bus.clear  = ($urandom % 97) == 0;
         if (($urandom % 64) == 0)
            bus.meanlen = (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'($urandom % 5);
         if (($urandom % 128) == 0) bus.mode = ~bus.mode;
         if (($urandom % 1500) == 0) begin
            reset = 1'b0;
            tick();
            reset = 1'b1;
         end
         tick();
      end

      bus.sample = 1'b0;
      bus.clear  = 1'b0;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
